// File: rtl/turbo_sched_pkg.sv
// Shared types and helpers for the turbo half-iteration scheduler.
package turbo_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_OUT_WAIT,
    S_DONE
  } sched_state_t;

  typedef logic [15:0] frame_cnt_t;

  // Bits needed to hold the values 0..x; never less than one bit.
  function automatic int cnt_w(input int x);
    return (x < 1) ? 1 : $clog2(x + 1);
  endfunction

endpackage

// File: rtl/turbo_sched_watchdog.sv
// Per-pass watchdog: cleared when a pass starts, counts while the pass runs,
// flags expiry once the count reaches TIMEOUT-1.
module turbo_sched_watchdog
  import turbo_sched_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = cnt_w(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Pass-cycle counter; holds at the last value so it never wraps.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LAST);

endmodule

// File: rtl/turbo_half_iter_sched.sv
// Turbo decoder half-iteration scheduler: accepts a frame, issues one SISO
// start per half-iteration with alternating ordering, stops on the iteration
// limit (or on convergence when TURBO_EARLY_STOP_EN is defined), guards each
// pass with a watchdog and hands the frame off when the output buffer is free.
module turbo_half_iter_sched
  import turbo_sched_pkg::*;
#(
  parameter int N         = 8,
  parameter int TAIL_BITS = 2,
  parameter int HALF_ITER = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            siso_start,
  output logic                            siso_interleaved,
  output logic [cnt_w(N+TAIL_BITS)-1:0]   siso_len,
  input  logic                            siso_done,
  input  logic                            hd_change,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic                            out_deinterleave,
  output logic [cnt_w(HALF_ITER)-1:0]     half_count,
  output logic                            timeout_err,
  output logic [15:0]                     frame_count
);

  localparam int HC_W  = cnt_w(HALF_ITER);
  localparam int LEN_W = cnt_w(N + TAIL_BITS);

  sched_state_t    r_state;
  sched_state_t    w_next;
  logic [HC_W-1:0] r_half;
  logic [HC_W-1:0] w_half_next;
  logic            r_inter;
  logic            r_timeout;
  frame_cnt_t      r_frames;
  logic            w_expire;
  logic            w_stop;

  turbo_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == S_START),
    .i_enable (r_state == S_RUN),
    .o_expire (w_expire)
  );

  assign w_half_next = r_half + 1'b1;

  // Decide whether the pass that just completed is the last one of the frame.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_stop = (w_half_next == HC_W'(HALF_ITER));
`ifdef TURBO_EARLY_STOP_EN
    if (!hd_change && (32'(w_half_next) >= 2) && !w_half_next[0]) begin
      w_stop = 1'b1;
    end
`endif
  end

`ifndef TURBO_EARLY_STOP_EN
  logic w_unused_hd;
  assign w_unused_hd = hd_change;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; a done in the expiry cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (in_valid) w_next = S_START;
      S_START:    w_next = S_RUN;
      S_RUN: begin
        if (siso_done)     w_next = w_stop ? S_OUT_WAIT : S_START;
        else if (w_expire) w_next = S_OUT_WAIT;
      end
      S_OUT_WAIT: if (out_ready) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Per-frame bookkeeping: pass count, ordering, timeout flag, frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half    <= '0;
      r_inter   <= 1'b0;
      r_timeout <= 1'b0;
      r_frames  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_half    <= '0;
            r_inter   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_RUN: begin
          if (siso_done) begin
            r_half <= w_half_next;
            if (!w_stop) r_inter <= ~r_inter;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
          end
        end
        S_DONE:  r_frames <= r_frames + 1'b1;
        default: ;
      endcase
    end
  end

  assign in_ready         = (r_state == S_IDLE);
  assign siso_start       = (r_state == S_START);
  assign siso_interleaved = r_inter;
  assign siso_len         = LEN_W'(N + TAIL_BITS);
  assign out_valid        = (r_state == S_DONE);
  assign out_deinterleave = (r_state == S_DONE) & r_inter;
  assign half_count       = r_half;
  assign timeout_err      = r_timeout;
  assign frame_count      = r_frames;

endmodule

// File: tb/tb_turbo_half_iter_sched.sv
// Self-checking bench for turbo_half_iter_sched. Main instance: HALF_ITER=4,
// TIMEOUT=16; second instance: defaults (HALF_ITER=1). The frame model follows
// TURBO_EARLY_STOP_EN if the bench is built with it.
module tb_turbo_half_iter_sched;

  localparam int HI  = 4;
  localparam int TO  = 16;
  localparam int LEN = 10;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance
  logic        in_valid, in_ready, siso_start, siso_interleaved;
  logic [3:0]  siso_len;
  logic        siso_done, hd_change, out_ready, out_valid, out_deinterleave;
  logic [2:0]  half_count;
  logic        timeout_err;
  logic [15:0] frame_count;

  // HALF_ITER=1 instance
  logic        in_valid1, in_ready1, siso_start1, siso_interleaved1;
  logic [3:0]  siso_len1;
  logic        siso_done1, out_valid1, out_deinterleave1;
  logic [0:0]  half_count1;
  logic        timeout_err1;
  logic [15:0] frame_count1;

  turbo_half_iter_sched #(.N(8), .TAIL_BITS(2), .HALF_ITER(HI), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .siso_start(siso_start), .siso_interleaved(siso_interleaved), .siso_len(siso_len),
    .siso_done(siso_done), .hd_change(hd_change), .out_ready(out_ready),
    .out_valid(out_valid), .out_deinterleave(out_deinterleave), .half_count(half_count),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  turbo_half_iter_sched u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .siso_start(siso_start1), .siso_interleaved(siso_interleaved1), .siso_len(siso_len1),
    .siso_done(siso_done1), .hd_change(1'b0), .out_ready(1'b1),
    .out_valid(out_valid1), .out_deinterleave(out_deinterleave1), .half_count(half_count1),
    .timeout_err(timeout_err1), .frame_count(frame_count1)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_start1 = 0;
  int frames_model = 0;

  // Count start pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (siso_start === 1'b1)  n_start++;
    if (siso_start1 === 1'b1) n_start1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("idle_reached", in_ready, 1);
  endtask

  // Drive one frame through the main instance, acting as the SISO engine.
  // hold: cycles out_ready stays low; starve: never answer the first pass;
  // fixed_d: if >0, every pass completes exactly fixed_d cycles after its start.
  task automatic run_frame(input int hold, input bit starve, input int fixed_d);
    int  passes = 0;
    bit  stop = 0;
    int  d;
    bit  hd;
    int  s0;
    int  exp_ilv;
    wait_idle();
    s0 = n_start;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("accept_in_ready_low", in_ready, 0);
    check("accept_timeout_clr", timeout_err, 0);
    check("siso_len", siso_len, LEN);
    while (!stop) begin
      check("pass_start", siso_start, 1);
      check("pass_ilv", siso_interleaved, passes % 2);
      check("pass_half", half_count, passes);
      if (starve) begin
        repeat (TO) step();
        check("to_not_yet", timeout_err, 0);
        step();
        check("to_set", timeout_err, 1);
        stop = 1;
      end else begin
        d  = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 6));
        hd = 1'($urandom_range(0, 1));
        repeat (d) step();
        siso_done = 1'b1;
        hd_change = hd;
        step();
        siso_done = 1'b0;
        hd_change = 1'b0;
        passes++;
        stop = (passes == HI);
`ifdef TURBO_EARLY_STOP_EN
        if (!hd && passes >= 2 && (passes % 2) == 0) stop = 1;
`endif
      end
    end
    exp_ilv = starve ? (passes % 2) : ((passes - 1) % 2);
    repeat (hold) begin
      check("hold_no_valid", out_valid, 0);
      check("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_deint", out_deinterleave, exp_ilv);
    check("out_half", half_count, passes);
    check("out_timeout", timeout_err, starve);
    check("out_frames_pre", frame_count, frames_model);
    check("start_count", n_start - s0, passes + int'(starve));
    step();
    frames_model = (frames_model + 1) % 65536;
    check("post_valid_low", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_frames", frame_count, frames_model);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; siso_done = 1'b0; hd_change = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; siso_done1 = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_start", siso_start, 0);
    check("rst_ilv", siso_interleaved, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_deint", out_deinterleave, 0);
    check("rst_half", half_count, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frames", frame_count, 0);
    rst = 1'b0;
    step();

    // HALF_ITER=1: one pass, done 5 cycles after start, out_valid 2 cycles after done.
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check("h1_start", siso_start1, 1);
    check("h1_ilv", siso_interleaved1, 0);
    repeat (5) step();
    siso_done1 = 1'b1;
    step();
    siso_done1 = 1'b0;
    check("h1_no_valid_d1", out_valid1, 0);
    step();
    check("h1_out_valid", out_valid1, 1);
    check("h1_deint", out_deinterleave1, 0);
    check("h1_half", half_count1, 1);
    step();
    check("h1_frames", frame_count1, 1);
    check("h1_one_start", n_start1, 1);
    check("h1_in_ready", in_ready1, 1);

    // Random frames on the main instance.
    for (int i = 0; i < 6; i++) run_frame(int'($urandom_range(0, 3)), 1'b0, 0);
    // Done exactly in the watchdog expiry cycle counts as done.
    run_frame(0, 1'b0, TO);
    // Watchdog abort, then a normal frame that must clear timeout_err.
    run_frame(1, 1'b1, 0);
    run_frame(0, 1'b0, 0);
    // Output buffer busy for 50 cycles.
    run_frame(50, 1'b0, 0);

    // Reset during the second pass (interleaved=1).
    wait_idle();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    siso_done = 1'b1;
    hd_change = 1'b1;
    step();
    siso_done = 1'b0;
    hd_change = 1'b0;
    check("pre_rst_start2", siso_start, 1);
    check("pre_rst_ilv", siso_interleaved, 1);
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_start", siso_start, 0);
    check("mid_rst_ilv", siso_interleaved, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_half", half_count, 0);
    check("mid_rst_timeout", timeout_err, 0);
    check("mid_rst_frames", frame_count, 0);
    frames_model = 0;
    step();
    rst = 1'b0;
    step();
    run_frame(0, 1'b0, 0);
    run_frame(2, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbo_half_iter_sched.md
# turbo_half_iter_sched

Sequencing controller for the turbo decoder's shared SISO pass engine. It accepts a loaded frame from the input ping-pong buffer and issues one start per half-iteration, alternating natural and interleaved ordering. It counts half-iterations, optionally terminates early on hard-decision convergence, and guards each pass with a watchdog. It releases the decoded frame to the output ping-pong buffer only when that buffer is free.

## Interface
- `N`, 8, information bits per frame (passed through to `siso_len`)
- `TAIL_BITS`, 2, tail bits per frame; `siso_len` = N+TAIL_BITS
- `HALF_ITER`, 1, maximum half-iterations per frame, ≥1
- `TIMEOUT`, 1024, cycles allowed from `siso_start` to `siso_done`, ≥2
- `clk` in 1, sole clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `in_valid` in 1, input buffer holds a complete frame
- `in_ready` out 1, controller can accept a frame
- `siso_start` out 1, one-cycle pulse that starts a SISO pass
- `siso_interleaved` out 1, ordering of current pass: 0 natural, 1 interleaved
- `siso_len` out $clog2(N+TAIL_BITS+1), pass length, constant N+TAIL_BITS
- `siso_done` in 1, one-cycle pulse at pass completion
- `hd_change` in 1, sampled with `siso_done`: hard decisions differ from previous pass
- `out_ready` in 1, output ping-pong buffer free
- `out_valid` out 1, one-cycle pulse: frame decoded, hand off
- `out_deinterleave` out 1, ordering of the last pass; valid with `out_valid`
- `half_count` out $clog2(HALF_ITER+1), completed half-iterations of the current frame
- `timeout_err` out 1, sticky; last frame aborted by watchdog
- `frame_count` out 16, frames handed off; wraps at 65535→0

## Operation
- States: IDLE, START, RUN, OUT_WAIT, DONE.
- IDLE: `in_ready`=1. `in_valid`=1 → START. On acceptance: `half_count`←0, `siso_interleaved`←0, `timeout_err`←0.
- START: `siso_start`=1 for exactly this cycle. Watchdog loads 0. Next state is RUN.
- RUN: watchdog increments each cycle.
  - On `siso_done`, `half_count`←`half_count`+1. Let h be the new value.
  - Stop condition: h==HALF_ITER, or the early-stop condition (see Configuration).
  - Stop → OUT_WAIT, `siso_interleaved` held.
  - Otherwise toggle `siso_interleaved` → START.
  - Watchdog reaches TIMEOUT-1 with no `siso_done`: `timeout_err`←1 → OUT_WAIT. The frame is still handed off, so the buffers do not deadlock.
- OUT_WAIT: `out_ready`=1 → DONE.
- DONE: `out_valid`=1 for one cycle. `out_deinterleave`=`siso_interleaved`. `frame_count`+1. Next state is IDLE.
- `in_ready` is low outside IDLE, and `in_valid` is ignored there. `siso_done` is ignored outside RUN.
- `siso_done` in the same cycle as watchdog expiry counts as done. `timeout_err` stays 0.
- `rst` mid-frame: return to IDLE immediately. Any pending pass is abandoned. The SISO must be reset by the same `rst`.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 1
  - `siso_start` 0
  - `siso_interleaved` 0
  - `out_valid` 0
  - `out_deinterleave` 0
  - `half_count` 0
  - `timeout_err` 0
  - `frame_count` 0
- All outputs are registered or Moore-decoded. There is no combinational path from inputs to outputs.
- `in_valid` accepted at cycle t → `siso_start` at t+1.
- `siso_done` at cycle d with continuation → `siso_start` at d+1. The gap between passes is 1 cycle.
- Last `siso_done` at d with `out_ready`=1 → `out_valid` at d+2, `in_ready` at d+3.
- `out_ready` low holds OUT_WAIT indefinitely. The watchdog is inactive there.

## Configuration
- `TURBO_EARLY_STOP_EN` defined: stop when `siso_done` has `hd_change`=0, h≥2 and h is even. Stopping only on even h means both constituent decoders have agreed and the last pass was interleaved.
- Undefined: `hd_change` is ignored; exactly HALF_ITER passes always run. The port stays present.

## Structure
- Package `turbo_sched_pkg`:
  - state enum `sched_state_t`
  - width function `cnt_w(int)` returning $clog2(x+1)
  - 16-bit `frame_cnt_t`
- Sub-module `turbo_sched_watchdog`: clear/enable/expire counter parameterized by TIMEOUT, instantiated once.

## Test plan
- HALF_ITER=1, `siso_done` 5 cycles after start, `out_ready`=1:
  - one `siso_start`, interleaved=0
  - `out_valid` 2 cycles after done, `out_deinterleave`=0
  - `frame_count`=1
- HALF_ITER=4, macro off:
  - starts show interleaved 0,1,0,1
  - `half_count` ends at 4; `out_deinterleave`=1
- Macro on, HALF_ITER=8, `hd_change`=0 from pass 1:
  - stop after h=2, not h=1
  - only 2 `siso_start` pulses
- TIMEOUT=16, no `siso_done`:
  - `timeout_err`=1 at cycle 16 of RUN, then `out_valid`
  - next accepted frame clears `timeout_err`
- `out_ready`=0 for 50 cycles after the last done:
  - no `out_valid` and `in_ready`=0 throughout
  - release → `out_valid` 1 cycle later
- `rst` asserted in RUN: all outputs return to reset values that cycle; a following frame decodes normally.
